// File: rtl/weight_buffer_loader_if.sv
// Command, weight stream and buffer write-port signals of weight_buffer_loader.
// The slave modport is the loader's view; master is the DMA/bench side.
interface weight_buffer_loader_if #(
  parameter int WEIGHT_BANK_BIT_WIDTH       = 64,
  parameter int WEIGHT_BANK_DEPTH           = 512,
  parameter int WEIGHT_BUFFER_BANK_COUNT    = 16,
  parameter int NUMBER_OF_PE_ARRAYS_PER_ROW = 3
);
  localparam int AW = $clog2(WEIGHT_BANK_DEPTH);

  logic                                                  i_start;
  logic [AW-1:0]                                         i_base_address;
  logic [AW:0]                                           i_row_count;
  logic [NUMBER_OF_PE_ARRAYS_PER_ROW-1:0]                i_array_mask;
  logic [WEIGHT_BANK_BIT_WIDTH-1:0]                      i_data;
  logic                                                  i_valid;
  logic                                                  o_ready;
  logic                                                  o_busy;
  logic                                                  o_done;
  logic [WEIGHT_BANK_BIT_WIDTH*WEIGHT_BUFFER_BANK_COUNT-1:0] o_weight_memory_data_in;
  logic [NUMBER_OF_PE_ARRAYS_PER_ROW-1:0]                o_weight_memory_en;
  logic [WEIGHT_BUFFER_BANK_COUNT-1:0]                   o_weight_memory_write_enable;
  logic [AW-1:0]                                         o_weight_memory_bus_address_in;

  modport slave (
    input  i_start, i_base_address, i_row_count, i_array_mask, i_data, i_valid,
    output o_ready, o_busy, o_done, o_weight_memory_data_in, o_weight_memory_en,
           o_weight_memory_write_enable, o_weight_memory_bus_address_in
  );

  modport master (
    output i_start, i_base_address, i_row_count, i_array_mask, i_data, i_valid,
    input  o_ready, o_busy, o_done, o_weight_memory_data_in, o_weight_memory_en,
           o_weight_memory_write_enable, o_weight_memory_bus_address_in
  );
endinterface

// File: rtl/weight_buffer_loader.sv
// Write-side sequencer: turns a row-count command plus a beat stream into bank writes.
// WEIGHT_LOADER_BROADCAST_EN: write all masked PE-array buffers, else only the lowest set one.
module weight_buffer_loader #(
  parameter int WEIGHT_BANK_BIT_WIDTH       = 64,
  parameter int WEIGHT_BANK_DEPTH           = 512,
  parameter int WEIGHT_BUFFER_BANK_COUNT    = 16,
  parameter int NUMBER_OF_PE_ARRAYS_PER_ROW = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  weight_buffer_loader_if.slave  bus
);
  localparam int W   = WEIGHT_BANK_BIT_WIDTH;
  localparam int BC  = WEIGHT_BUFFER_BANK_COUNT;
  localparam int N   = NUMBER_OF_PE_ARRAYS_PER_ROW;
  localparam int AW  = $clog2(WEIGHT_BANK_DEPTH);
  localparam int BCW = (BC > 1) ? $clog2(BC) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t          state_reg;
  logic [BCW-1:0]  bank_cnt_reg;
  logic [AW-1:0]   row_addr_reg;
  logic [AW:0]     rows_left_reg;
  logic [N-1:0]    mask_reg;

  logic            ready_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [W*BC-1:0] data_reg;
  logic [N-1:0]    en_reg;
  logic [BC-1:0]   we_reg;
  logic [AW-1:0]   addr_reg;

  logic [N-1:0]    mask_next;
  logic [W*BC-1:0] data_rep;
  logic            handshake;
  logic            bank_last;
  logic            row_last;

`ifdef WEIGHT_LOADER_BROADCAST_EN
  assign mask_next = bus.i_array_mask;
`else
  // Isolate the lowest set bit so at most one buffer is ever enabled.
  assign mask_next = bus.i_array_mask & (~bus.i_array_mask + N'(1));
`endif

  genvar gi;
  generate
    for (gi = 0; gi < BC; gi++) begin : g_lane
      assign data_rep[gi*W +: W] = bus.i_data;
    end
  endgenerate

  assign handshake = bus.i_valid & ready_reg;
  assign bank_last = (bank_cnt_reg == BCW'(BC - 1));
  assign row_last  = (rows_left_reg == (AW+1)'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      bank_cnt_reg  <= '0;
      row_addr_reg  <= '0;
      rows_left_reg <= '0;
      mask_reg      <= '0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      data_reg      <= '0;
      en_reg        <= '0;
      we_reg        <= '0;
      addr_reg      <= '0;
    end else begin
      // Strobes are single-cycle; data and address hold between writes.
      en_reg   <= '0;
      we_reg   <= '0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.i_start) begin
            row_addr_reg  <= bus.i_base_address;
            rows_left_reg <= bus.i_row_count;
            mask_reg      <= mask_next;
            bank_cnt_reg  <= '0;
            busy_reg      <= 1'b1;
            if (bus.i_row_count == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= LOAD;
              ready_reg <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (handshake) begin
            we_reg   <= BC'(1) << bank_cnt_reg;
            en_reg   <= mask_reg;
            addr_reg <= row_addr_reg;
            data_reg <= data_rep;
            if (bank_last) begin
              bank_cnt_reg  <= '0;
              rows_left_reg <= rows_left_reg - (AW+1)'(1);
              row_addr_reg  <= (row_addr_reg == AW'(WEIGHT_BANK_DEPTH - 1)) ?
                               '0 : row_addr_reg + AW'(1);
              if (row_last) begin
                state_reg <= DONE;
                ready_reg <= 1'b0;
                done_reg  <= 1'b1;
              end
            end else begin
              bank_cnt_reg <= bank_cnt_reg + BCW'(1);
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready                        = ready_reg;
  assign bus.o_busy                         = busy_reg;
  assign bus.o_done                         = done_reg;
  assign bus.o_weight_memory_data_in        = data_reg;
  assign bus.o_weight_memory_en             = en_reg;
  assign bus.o_weight_memory_write_enable   = we_reg;
  assign bus.o_weight_memory_bus_address_in = addr_reg;
endmodule

// File: tb/tb_weight_buffer_loader.sv
// Scoreboard bench for weight_buffer_loader: a driver queues expected writes from a
// row/bank reference model, a negedge monitor pops and compares every strobe and done.
module tb_weight_buffer_loader;
  localparam int W  = 64;
  localparam int D  = 512;
  localparam int BC = 16;
  localparam int N  = 3;
  localparam int AW = $clog2(D);

  typedef struct packed {
    logic [N-1:0]  en;
    logic [BC-1:0] we;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  weight_buffer_loader_if #(
    .WEIGHT_BANK_BIT_WIDTH(W), .WEIGHT_BANK_DEPTH(D),
    .WEIGHT_BUFFER_BANK_COUNT(BC), .NUMBER_OF_PE_ARRAYS_PER_ROW(N)
  ) bus ();

  weight_buffer_loader #(
    .WEIGHT_BANK_BIT_WIDTH(W), .WEIGHT_BANK_DEPTH(D),
    .WEIGHT_BUFFER_BANK_COUNT(BC), .NUMBER_OF_PE_ARRAYS_PER_ROW(N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  wr_t sb[$];
  bit  done_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference mask: whole mask when broadcasting, otherwise the first set bit from bit 0.
  function automatic logic [N-1:0] model_mask(input logic [N-1:0] m);
`ifdef WEIGHT_LOADER_BROADCAST_EN
    return m;
`else
    for (int i = 0; i < N; i++)
      if (m[i]) return N'(1) << i;
    return '0;
`endif
  endfunction

  wr_t             mon_e;
  logic [W*BC-1:0] mon_rep;
  bit              mon_ns;
  bit              prev_done = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (bus.o_weight_memory_write_enable != '0) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_write", 64'(bus.o_weight_memory_write_enable), 64'd0);
        end else begin
          mon_e   = sb.pop_front();
          mon_rep = {BC{mon_e.data}};
          chk(bus.o_weight_memory_write_enable == mon_e.we, "bank_strobe",
              64'(bus.o_weight_memory_write_enable), 64'(mon_e.we));
          chk(bus.o_weight_memory_en == mon_e.en, "array_en",
              64'(bus.o_weight_memory_en), 64'(mon_e.en));
          chk(bus.o_weight_memory_bus_address_in == mon_e.addr, "row_address",
              64'(bus.o_weight_memory_bus_address_in), 64'(mon_e.addr));
          chk(bus.o_weight_memory_data_in == mon_rep, "replicated_data",
              bus.o_weight_memory_data_in[W-1:0], mon_e.data);
        end
      end else if (bus.o_weight_memory_en != '0) begin
        chk(1'b0, "en_without_strobe", 64'(bus.o_weight_memory_en), 64'd0);
      end
      if (bus.o_done) begin
        if (done_q.size() == 0) begin
          chk(1'b0, "unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_ns = done_q.pop_front();
          chk(sb.size() == 0, "done_with_pending_writes", 64'(sb.size()), 64'd0);
          if (mon_ns)
            chk(bus.o_weight_memory_write_enable != '0, "done_with_last_strobe",
                64'(bus.o_weight_memory_write_enable), 64'd1);
          chk(bus.o_busy == 1'b1, "busy_during_done", 64'(bus.o_busy), 64'd1);
          chk(bus.o_ready == 1'b0, "ready_during_done", 64'(bus.o_ready), 64'd0);
        end
      end
      if (prev_done)
        chk(bus.o_busy == 1'b0, "busy_after_done", 64'(bus.o_busy), 64'd0);
      prev_done = bus.o_done;
    end
  end

  task automatic check_all_zero(input string tag);
    chk(bus.o_ready == 1'b0, {tag, "_ready"}, 64'(bus.o_ready), 64'd0);
    chk(bus.o_busy == 1'b0, {tag, "_busy"}, 64'(bus.o_busy), 64'd0);
    chk(bus.o_done == 1'b0, {tag, "_done"}, 64'(bus.o_done), 64'd0);
    chk(bus.o_weight_memory_en == '0, {tag, "_en"}, 64'(bus.o_weight_memory_en), 64'd0);
    chk(bus.o_weight_memory_write_enable == '0, {tag, "_we"},
        64'(bus.o_weight_memory_write_enable), 64'd0);
    chk(bus.o_weight_memory_bus_address_in == '0, {tag, "_addr"},
        64'(bus.o_weight_memory_bus_address_in), 64'd0);
    chk(bus.o_weight_memory_data_in == '0, {tag, "_data"},
        bus.o_weight_memory_data_in[W-1:0], 64'd0);
  endtask

  // One command: queue expectations, issue i_start, stream beats with random bubbles.
  task automatic run_cmd(input logic [AW-1:0] base, input int rows, input logic [N-1:0] mask,
                         input int gap_pct, input bit counting, input int start_pulse_at,
                         input int abort_after);
    logic [W-1:0] beats[$];
    wr_t          e;
    int           total;
    int           n_exp;
    int           idx;
    int           budget;
    int           w;
    bit           hs;
    total = rows * BC;
    for (int i = 0; i < total; i++)
      beats.push_back(counting ? W'(i) : {$urandom, $urandom});
    n_exp = (abort_after >= 0) ? abort_after : total;
    for (int i = 0; i < n_exp; i++) begin
      e.addr = AW'((int'(base) + i / BC) % D);
      e.we   = BC'(1) << (i % BC);
      e.en   = model_mask(mask);
      e.data = beats[i];
      sb.push_back(e);
    end
    if (abort_after < 0) done_q.push_back(rows != 0);

    @(negedge clk);
    bus.i_start        = 1'b1;
    bus.i_base_address = base;
    bus.i_row_count    = (AW+1)'(rows);
    bus.i_array_mask   = mask;
    @(negedge clk);
    bus.i_start        = 1'b0;
    bus.i_base_address = AW'($urandom);
    bus.i_array_mask   = N'($urandom);
    chk(bus.o_busy == 1'b1, "busy_after_start", 64'(bus.o_busy), 64'd1);
    if (rows == 0) begin
      chk(bus.o_done == 1'b1, "zero_row_done_latency", 64'(bus.o_done), 64'd1);
      chk(bus.o_ready == 1'b0, "zero_row_ready", 64'(bus.o_ready), 64'd0);
    end else begin
      chk(bus.o_ready == 1'b1, "start_latency_ready", 64'(bus.o_ready), 64'd1);
    end

    idx = 0;
    budget = 0;
    while (idx < total && (abort_after < 0 || idx < abort_after)) begin
      if (budget > 4000) begin
        chk(1'b0, "beat_timeout", 64'(idx), 64'(total));
        break;
      end
      bus.i_valid = ($urandom_range(99) >= gap_pct);
      bus.i_data  = bus.i_valid ? beats[idx] : {$urandom, $urandom};
      bus.i_start = (idx == start_pulse_at);
      if (bus.i_start) begin
        bus.i_row_count    = '0;
        bus.i_base_address = AW'($urandom);
        bus.i_array_mask   = N'($urandom);
      end
      hs = bus.i_valid && bus.o_ready;
      @(negedge clk);
      budget++;
      if (hs) idx++;
    end
    bus.i_valid = 1'b0;
    bus.i_start = 1'b0;

    if (abort_after >= 0) begin
      #1 reset = 1'b1;
      #1;
      check_all_zero("abort");
      chk(sb.size() == 0, "abort_writes_seen", 64'(sb.size()), 64'd0);
      sb.delete();
      done_q.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk(bus.o_busy == 1'b0 && bus.o_ready == 1'b0, "idle_after_abort",
            64'({bus.o_busy, bus.o_ready}), 64'd0);
      end
      $display("cmd base=%0d rows=%0d mask=%b aborted after %0d beats", base, rows, mask, idx);
    end else begin
      w = 0;
      while (done_q.size() != 0 && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk(done_q.size() == 0, "done_timeout", 64'(done_q.size()), 64'd0);
      chk(sb.size() == 0, "all_writes_seen", 64'(sb.size()), 64'd0);
      @(negedge clk);
      chk(bus.o_ready == 1'b0, "ready_low_in_idle", 64'(bus.o_ready), 64'd0);
      done_q.delete();
      sb.delete();
      $display("cmd base=%0d rows=%0d mask=%b beats=%0d complete", base, rows, mask, idx);
    end
  endtask

  initial begin
    bus.i_start        = 1'b0;
    bus.i_base_address = '0;
    bus.i_row_count    = '0;
    bus.i_array_mask   = '0;
    bus.i_data         = '0;
    bus.i_valid        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");

    run_cmd(AW'(0),   1, 3'b001, 0,  1'b1, -1, -1);
    run_cmd(AW'(510), 3, 3'b010, 35, 1'b0, 20, -1);
    run_cmd(AW'(77),  1, 3'b101, 20, 1'b0, -1, -1);
    run_cmd(AW'(300), 0, 3'b011, 0,  1'b0, -1, -1);
    run_cmd(AW'(12),  2, 3'b000, 25, 1'b0, -1, -1);
    run_cmd(AW'(40),  2, 3'b110, 0,  1'b0, -1, 20);
    for (int k = 0; k < 4; k++)
      run_cmd(AW'($urandom_range(D - 1)), $urandom_range(2, 0), N'($urandom),
              $urandom_range(50), 1'b0, $urandom_range(40), -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
